// File: rtl/dense_layer.sv
// rtl/dense_layer.sv - fixed-point dense layer: packed activation x weight MAC, requantize, saturate
// Optional bias add enabled by defining DENSE_BIAS_EN.
module dense_layer #(
    parameter int IN_SIZE              = 1764,
    parameter int OUT_SIZE             = 10,
    parameter int BIT_WIDTH            = 16,
    parameter int RAM_WIDTH_MULTIPLIER = 2,
    parameter int FRAC_BITS            = 8,
    parameter int ACC_WIDTH            = 48,
    localparam int M        = RAM_WIDTH_MULTIPLIER,
    localparam int IN_WORDS = (IN_SIZE + M - 1) / M,
    localparam int AW       = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1,
    localparam int WAW      = (OUT_SIZE * IN_WORDS > 1) ? $clog2(OUT_SIZE * IN_WORDS) : 1,
    localparam int OW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [AW-1:0]          addr_rd,
    input  logic [BIT_WIDTH*M-1:0] data_rd,
    output logic [WAW-1:0]         wgt_addr,
    input  logic [BIT_WIDTH*M-1:0] wgt_rd,
    output logic [OW-1:0]          bias_addr,
    input  logic [BIT_WIDTH-1:0]   bias_rd,
    output logic [OW-1:0]          addr_wr,
    output logic [BIT_WIDTH-1:0]   data_wr,
    output logic                   wren,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

    localparam logic [AW-1:0] LAST_W = AW'(IN_WORDS - 1);
    localparam logic [OW-1:0] LAST_O = OW'(OUT_SIZE - 1);
    localparam logic signed [ACC_WIDTH-1:0] MAXV =
        {{(ACC_WIDTH-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MINV =
        {{(ACC_WIDTH-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    state_t state, state_nx;
    logic [AW-1:0] w;
    logic [OW-1:0] o;
    logic signed [ACC_WIDTH-1:0] acc, word_sum, acc_b, t;
    logic signed [BIT_WIDTH-1:0] lane_a, lane_b;
    logic signed [2*BIT_WIDTH-1:0] prod;
    logic [BIT_WIDTH-1:0] r;
    int widx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = FETCH;
            FETCH:      if (w == LAST_W) state_nx = DRAIN;
            DRAIN:      state_nx = WRITE;
            WRITE:      state_nx = (o == LAST_O) ? DONE : FETCH;
            default:    state_nx = IDLE;
        endcase
    end

    // data_rd holds the word addressed one cycle earlier: w-1 in FETCH, the last word in DRAIN
    always_comb begin
        word_sum = '0;
        lane_a   = '0;
        lane_b   = '0;
        prod     = '0;
        widx     = (state == DRAIN) ? (IN_WORDS - 1) : (int'(w) - 1);
        for (int i = 0; i < M; i++) begin
            lane_a = data_rd[BIT_WIDTH*i +: BIT_WIDTH];
            lane_b = wgt_rd[BIT_WIDTH*i +: BIT_WIDTH];
            prod   = lane_a * lane_b;
            if (widx * M + i < IN_SIZE)
                word_sum = word_sum + {{(ACC_WIDTH-2*BIT_WIDTH){prod[2*BIT_WIDTH-1]}}, prod};
        end
    end

`ifdef DENSE_BIAS_EN
    logic signed [ACC_WIDTH-1:0] bias_ext;
    assign bias_ext = {{(ACC_WIDTH-BIT_WIDTH){bias_rd[BIT_WIDTH-1]}}, bias_rd};
    assign acc_b    = acc + (bias_ext <<< FRAC_BITS);
`else
    logic unused_bias;
    assign unused_bias = ^bias_rd;
    assign acc_b       = acc;
`endif

    always_comb begin
        t = acc_b >>> FRAC_BITS;
        if (t > MAXV)      r = MAXV[BIT_WIDTH-1:0];
        else if (t < MINV) r = MINV[BIT_WIDTH-1:0];
        else               r = t[BIT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o         <= '0;
            w         <= '0;
            acc       <= '0;
            addr_rd   <= '0;
            wgt_addr  <= '0;
            bias_addr <= '0;
            addr_wr   <= '0;
            data_wr   <= '0;
            wren      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wren <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    o        <= '0;
                    w        <= '0;
                    acc      <= '0;
                    addr_rd  <= '0;
                    wgt_addr <= '0;
`ifdef DENSE_BIAS_EN
                    bias_addr <= '0;
`endif
                    busy     <= 1'b1;
                    done     <= 1'b0;
                end
                FETCH: begin
                    if (w != '0) acc <= acc + word_sum;
                    if (w != LAST_W) begin
                        w        <= w + AW'(1);
                        addr_rd  <= w + AW'(1);
                        wgt_addr <= wgt_addr + WAW'(1);
                    end
                end
                DRAIN: acc <= acc + word_sum;
                WRITE: begin
                    data_wr <= r;
                    addr_wr <= o;
                    wren    <= 1'b1;
                    if (o == LAST_O) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        // weight words are contiguous, so the next neuron's base follows directly
                        o        <= o + OW'(1);
                        w        <= '0;
                        acc      <= '0;
                        addr_rd  <= '0;
                        wgt_addr <= wgt_addr + WAW'(1);
`ifdef DENSE_BIAS_EN
                        bias_addr <= o + OW'(1);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
